// File: rtl/param_right_barrel_shifter_pkg.sv
//------------------------------------------------------------------------------
// Module  : param_right_barrel_shifter_pkg
// Brief   : Shared helpers for the logarithmic right-rotate datapath.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package param_right_barrel_shifter_pkg;

    localparam int c_MAX_N = 6;

    // Rotate distance handled by stage k of the log-shifter chain.
    function automatic int stage_dist(input int k);
        return 1 << k;
    endfunction

endpackage

`default_nettype wire

// File: rtl/param_right_barrel_shifter_rotr_stage.sv
//------------------------------------------------------------------------------
// Module  : rotr_stage
// Brief   : One mux level: rotate right by fixed distance D, or pass through.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rotr_stage #(
    parameter int W = 4,
    parameter int D = 1
) (
    input  logic [W-1:0] din,
    input  logic         sel,
    output logic [W-1:0] dout
);

    logic [2*W-1:0] w_dbl;
    logic [W-1:0]   w_rot;

    // Bit i of the rotated word is din[(i+D) mod W], i.e. bit i+D of {din,din}.
    assign w_dbl = {din, din};
    assign w_rot = w_dbl[D +: W];
    assign dout  = sel ? w_rot : din;

endmodule

`default_nettype wire

// File: rtl/param_right_barrel_shifter.sv
//------------------------------------------------------------------------------
// Module  : param_right_barrel_shifter
// Brief   : Registered 2^N-bit rotate-right by a run-time amount (N mux levels).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module param_right_barrel_shifter
    import param_right_barrel_shifter_pkg::*;
#(
    parameter int N = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [2**N-1:0] a,
    input  logic [N-1:0]   amt,
    output logic [2**N-1:0] y
);

    localparam int c_W = 2**N;

    logic [N:0][c_W-1:0] w_stage;
    logic [c_W-1:0]      r_y;

    assign w_stage[0] = a;

    generate
        for (genvar k = 0; k < N; k++) begin : g_stage
            rotr_stage #(
                .W (c_W),
                .D (stage_dist(k))
            ) u_rotr_stage (
                .din  (w_stage[k]),
                .sel  (amt[k]),
                .dout (w_stage[k+1])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_y <= '0;
        end else begin
            r_y <= w_stage[N];
        end
    end

    assign y = r_y;

endmodule

`default_nettype wire

// File: tb/tb_param_right_barrel_shifter.sv
//------------------------------------------------------------------------------
// Module  : tb_param_right_barrel_shifter
// Brief   : Self-checking bench for N=2 and N=3 rotate-right instances.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_param_right_barrel_shifter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] a2;
    logic [1:0] amt2;
    logic [3:0] y2;
    logic [7:0] a3;
    logic [2:0] amt3;
    logic [7:0] y3;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] a;
        logic [1:0] amt;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    param_right_barrel_shifter #(.N(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .a     (a2),
        .amt   (amt2),
        .y     (y2)
    );

    param_right_barrel_shifter #(.N(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .a     (a3),
        .amt   (amt3),
        .y     (y3)
    );

    // Reference: result bit i takes source bit (i + amt) mod w.
    function automatic logic [7:0] rot_model(input logic [7:0] v, input int amt, input int w);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = v[(i + amt) % w];
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive away from the active edge, then sample just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rnd;
        logic [7:0]  e2, e3;

        vecs[0] = '{4'b0110, 2'b01, 4'b0011};
        vecs[1] = '{4'b1100, 2'b01, 4'b0110};
        vecs[2] = '{4'b0011, 2'b10, 4'b1100};
        vecs[3] = '{4'b0001, 2'b11, 4'b0010};
        vecs[4] = '{4'b1010, 2'b00, 4'b1010};

        reset = 1'b1;
        a2 = 4'b1111; amt2 = 2'b01;
        a3 = 8'hff;   amt3 = 3'd5;
        @(negedge clk);

        for (int c = 0; c < 2; c++) begin
            step();
            check("reset_y2", {4'b0, y2}, 8'h00);
            check("reset_y3", y3, 8'h00);
        end

        @(negedge clk);
        reset = 1'b0;
        step();
        check("release_y2", {4'b0, y2}, 8'h0f);

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a2 = vecs[i].a; amt2 = vecs[i].amt;
            step();
            check($sformatf("vec%0d", i), {4'b0, y2}, {4'b0, vecs[i].exp});
        end

        @(negedge clk);
        a3 = 8'b1000_0001; amt3 = 3'd3;
        step();
        check("n3_amt3", y3, 8'b0011_0000);
        @(negedge clk);
        amt3 = 3'd7;
        step();
        check("n3_amt7", y3, 8'b0000_0011);

        // Back-to-back sweep of every N=2 input, one-cycle reset at i==30.
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            a2    = 4'(i);
            amt2  = 2'(i >> 4);
            reset = (i == 30);
            e2    = reset ? 8'h00 : rot_model({4'b0, a2}, int'(amt2), 4);
            step();
            check($sformatf("sweep%0d", i), {4'b0, y2}, e2);
        end

        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            rnd   = $urandom;
            a2    = rnd[3:0];
            amt2  = rnd[5:4];
            a3    = rnd[13:6];
            amt3  = rnd[16:14];
            reset = (rnd[21:18] == 4'd0);
            e2    = reset ? 8'h00 : rot_model({4'b0, a2}, int'(amt2), 4);
            e3    = reset ? 8'h00 : rot_model(a3, int'(amt3), 8);
            step();
            check($sformatf("rand2_%0d", i), {4'b0, y2}, e2);
            check($sformatf("rand3_%0d", i), y3, e3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
